aqp_ebus_arbiter: RTL and testbench
===================================

# aqp_ebus_arbiter

Parametrised external-bus arbiter for the Aquarius+ FPGA cores, replacing the fixed two-way SPI-master/T80 bus muxing in the top level. It arbitrates NUM_MASTERS internal bus masters onto the shared Z80 bus (ebus) with fixed-priority or round-robin selection. It requests the bus from the external Z80 through BUSREQ/BUSACK and inserts a released-bus turnaround between owners. It also produces synchronized, edge-detected read/write strobes for bus-slave logic in the common core.

## Interface
- NUM_MASTERS, 3: number of internal masters, 2..4; index 0 is highest fixed priority.
- SYNC_STAGES, 2: synchronizer depth for ebus RD#/WR#/BUSACK# inputs, 2..3.
- TURNAROUND, 1: cycles with all ebus outputs released between owners, 1..7.
- clk  in  1  system clock, 28.63636MHz.
- reset_n  in  1  asynchronous active-low reset.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- has_ext  in  1  1 = external Z80 present; BUSREQ/BUSACK handshake required.
- m_req  in  NUM_MASTERS  per-master bus request, level.
- m_gnt  out  NUM_MASTERS  one-hot grant, registered.
- m_a  in  16*NUM_MASTERS  per-master address, master i at [16i+15:16i].
- m_d  in  8*NUM_MASTERS  per-master write data.
- m_d_oe  in  NUM_MASTERS  per-master data drive enable.
- m_rd_n, m_wr_n, m_mreq_n, m_iorq_n  in  NUM_MASTERS each  per-master strobes.
- bus_a  out  16  muxed address of owner.
- bus_d  out  8  muxed write data of owner.
- bus_d_oe  out  1  bus_oe AND owner m_d_oe.
- bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n  out  1 each  muxed owner strobes; forced 1 when bus_oe=0.
- bus_oe  out  1  drive enable for ebus address/control pins, registered.
- owner  out  2  index of current/last owner.
- ext_busreq_n  out  1  BUSREQ# to external Z80, registered.
- ext_busack_n  in  1  BUSACK# from external Z80, asynchronous.
- ebus_rd_n_in, ebus_wr_n_in  in  1 each  ebus RD#/WR# pin levels, asynchronous.
- rd_stb, wr_stb  out  1 each  one-cycle pulse on synchronized falling edge.

## Operation
- States: IDLE, EXTREQ, GRANT, RELEASE.
- IDLE: if any m_req, latch winner into owner. With has_ext=1 and synchronized BUSACK# high, go to EXTREQ. Otherwise go to GRANT.
- Winner selection, fixed priority: lowest requesting index.
- Winner selection, round-robin: first requesting index after last owner, wrapping NUM_MASTERS-1 -> 0.
- EXTREQ: ext_busreq_n=0. Wait for synchronized ext_busack_n=0, then go to GRANT. If m_req[owner] drops first, return to IDLE and keep ext_busreq_n=0 while any request is pending.
- GRANT: m_gnt[owner]=1, bus_oe=1, bus outputs follow owner combinationally. Leave only when m_req[owner]=0 and owner rd/wr/mreq/iorq are all 1; a request dropped mid-cycle is held until the strobes go idle. Then go to RELEASE.
- RELEASE: m_gnt=0, bus_oe=0, count TURNAROUND cycles, then go to IDLE.
- ext_busreq_n deasserts (1) on leaving RELEASE when no m_req is set. Otherwise it stays 0, so back-to-back owners never re-handshake.
- Strobes: ebus_rd_n_in/ebus_wr_n_in pass through SYNC_STAGES flops plus one history flop. rd_stb = history 1 and current 0 (wr_stb likewise). Strobes are generated regardless of owner.

## Timing
- Reset values: m_gnt=0, bus_oe=0, bus_d_oe=0, all bus strobes 1, ext_busreq_n=1, owner=NUM_MASTERS-1 (round-robin starts at 0), rd_stb=wr_stb=0, state IDLE, synchronizers preset to 1.
- Reset is asynchronous: bus_oe and m_gnt drop in the same instant, including mid bus cycle.
- Grant latency, has_ext=0: m_req rises at edge N, so m_gnt and bus_oe are 1 after edge N+1.
- Grant latency, has_ext=1: ext_busreq_n=0 after edge N+1. m_gnt is 1 one cycle after the synchronized BUSACK# low, i.e. SYNC_STAGES+1 cycles after the pin falls.
- Release: m_req[owner] falls with strobes idle at edge N. m_gnt=0 and bus_oe=0 after edge N+1. Next grant is no earlier than edge N+1+TURNAROUND+1.
- Simultaneous requests in IDLE resolve in one cycle. A request appearing during RELEASE waits for IDLE.
- rd_stb/wr_stb lag the pin edge by SYNC_STAGES+1 cycles and are exactly one cycle wide; a low pulse shorter than one clk may be missed.

## Test plan
- has_ext=0, TURNAROUND=1: m_req=3'b001 at cycle 0 -> m_gnt=001 and bus_oe=1 at cycle 1; bus_a equals m_a[15:0]. Drop req -> bus_oe=0 at the next cycle, IDLE 2 cycles later.
- Fixed priority: m_req=3'b110 -> grant 010. Round-robin with owner=1 and m_req=3'b111 held -> grant sequence 2,0,1,2, each separated by a TURNAROUND bus_oe=0 gap.
- has_ext=1: req at cycle 0 -> ext_busreq_n=0 at cycle 1; hold BUSACK# high 10 cycles -> no grant; drive BUSACK# low -> grant exactly 3 cycles later (SYNC_STAGES=2).
- Owner drops m_req while m_wr_n=0 -> m_gnt stays 1 until m_wr_n=1, then releases next cycle.
- Pulse ebus_wr_n_in low for 4 cycles -> single wr_stb pulse 3 cycles after the falling edge; rd_stb stays 0.
- Assert reset_n=0 mid-grant -> m_gnt=0, bus_oe=0, ext_busreq_n=1 immediately. After release, req=3'b100 -> grant 100 in 1 cycle.

Source files
------------

// File: rtl/aqp_ebus_arbiter.sv
// External Z80 bus arbiter: grants one of NUM_MASTERS internal masters the ebus,
// handles the BUSREQ/BUSACK handshake and generates synchronized RD#/WR# strobes.
module aqp_ebus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rr_mode,
  input  logic                     has_ext,
  input  logic [NUM_MASTERS-1:0]   m_req,
  output logic [NUM_MASTERS-1:0]   m_gnt,
  input  logic [16*NUM_MASTERS-1:0] m_a,
  input  logic [8*NUM_MASTERS-1:0] m_d,
  input  logic [NUM_MASTERS-1:0]   m_d_oe,
  input  logic [NUM_MASTERS-1:0]   m_rd_n,
  input  logic [NUM_MASTERS-1:0]   m_wr_n,
  input  logic [NUM_MASTERS-1:0]   m_mreq_n,
  input  logic [NUM_MASTERS-1:0]   m_iorq_n,
  output logic [15:0]              bus_a,
  output logic [7:0]               bus_d,
  output logic                     bus_d_oe,
  output logic                     bus_rd_n,
  output logic                     bus_wr_n,
  output logic                     bus_mreq_n,
  output logic                     bus_iorq_n,
  output logic                     bus_oe,
  output logic [1:0]               owner,
  output logic                     ext_busreq_n,
  input  logic                     ext_busack_n,
  input  logic                     ebus_rd_n_in,
  input  logic                     ebus_wr_n_in,
  output logic                     rd_stb,
  output logic                     wr_stb
);

  typedef enum logic [1:0] {IDLE, EXTREQ, GRANT, RELEASE} state_t;

  localparam logic [2:0] TA_LAST = 3'(TURNAROUND - 1);

  state_t                 state, state_d;
  logic [1:0]             owner_d, fp_win, rr_win, rr_cand;
  logic                   rr_found;
  logic [2:0]             ta_cnt, ta_cnt_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic                   oe_d, busreq_d;

  // Per-master signals padded to four entries so a 2-bit owner indexes them directly.
  logic [3:0]  req4, doe4, rd4, wr4, mreq4, iorq4;
  logic [15:0] a4 [4];
  logic [7:0]  d4 [4];

  for (genvar g = 0; g < 4; g++) begin : g_port
    if (g < NUM_MASTERS) begin : g_used
      assign req4[g]  = m_req[g];
      assign doe4[g]  = m_d_oe[g];
      assign rd4[g]   = m_rd_n[g];
      assign wr4[g]   = m_wr_n[g];
      assign mreq4[g] = m_mreq_n[g];
      assign iorq4[g] = m_iorq_n[g];
      assign a4[g]    = m_a[16*g +: 16];
      assign d4[g]    = m_d[8*g +: 8];
    end else begin : g_pad
      assign req4[g]  = 1'b0;
      assign doe4[g]  = 1'b0;
      assign rd4[g]   = 1'b1;
      assign wr4[g]   = 1'b1;
      assign mreq4[g] = 1'b1;
      assign iorq4[g] = 1'b1;
      assign a4[g]    = '0;
      assign d4[g]    = '0;
    end
  end

  logic [SYNC_STAGES-1:0] ack_sync, rd_sync, wr_sync;
  logic                   rd_hist, wr_hist;
  logic                   ack_n_s, any_req, own_req, own_idle;

  assign ack_n_s  = ack_sync[SYNC_STAGES-1];
  assign any_req  = |m_req;
  assign own_req  = req4[owner];
  assign own_idle = rd4[owner] & wr4[owner] & mreq4[owner] & iorq4[owner];

  // Winner selection: fixed priority (lowest index) and round-robin (first after owner).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fp_win   = 2'd0;
    rr_win   = 2'd0;
    rr_cand  = 2'd0;
    rr_found = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (req4[2'(k)]) fp_win = 2'(k);
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_cand = 2'((int'(owner) + k) % NUM_MASTERS);
      if (!rr_found && req4[rr_cand]) begin
        rr_win   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= 2'(NUM_MASTERS - 1);
      ta_cnt       <= '0;
      m_gnt        <= '0;
      bus_oe       <= 1'b0;
      ext_busreq_n <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state        <= state_d;
      owner        <= owner_d;
      ta_cnt       <= ta_cnt_d;
      m_gnt        <= gnt_d;
      bus_oe       <= oe_d;
      ext_busreq_n <= busreq_d;
    end
  end

  always_comb begin
    state_d  = state;
    owner_d  = owner;
    ta_cnt_d = ta_cnt;
    case (state)
      IDLE: if (any_req) begin
        owner_d = rr_mode ? rr_win : fp_win;
        state_d = (has_ext && ack_n_s) ? EXTREQ : GRANT;
      end
      EXTREQ: begin
        if (!own_req)      state_d = IDLE;
        else if (!ack_n_s) state_d = GRANT;
      end
      // A dropped request is only honoured once the owner's strobes are idle.
      GRANT: if (!own_req && own_idle) begin
        state_d  = RELEASE;
        ta_cnt_d = '0;
      end
      RELEASE: begin
        if (ta_cnt == TA_LAST) state_d = IDLE;
        else                   ta_cnt_d = ta_cnt + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they appear with it.
  always_comb begin
    oe_d     = (state_d == GRANT);
    gnt_d    = (state_d == GRANT) ? (NUM_MASTERS'(1) << owner_d) : '0;
    busreq_d = ext_busreq_n;
    case (state)
      IDLE: begin
        if (state_d == EXTREQ || (state_d == GRANT && has_ext)) busreq_d = 1'b0;
        else if (!any_req)                                        busreq_d = 1'b1;
      end
      EXTREQ:  if (state_d == IDLE) busreq_d = !any_req;
      RELEASE: if (state_d == IDLE && !any_req) busreq_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus_a      = a4[owner];
    bus_d      = d4[owner];
    bus_d_oe   = bus_oe & doe4[owner];
    bus_rd_n   = bus_oe ? rd4[owner]   : 1'b1;
    bus_wr_n   = bus_oe ? wr4[owner]   : 1'b1;
    bus_mreq_n = bus_oe ? mreq4[owner] : 1'b1;
    bus_iorq_n = bus_oe ? iorq4[owner] : 1'b1;
  end

  // Synchronizers preset to the idle (high) level so reset release creates no strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync <= '1;
      rd_sync  <= '1;
      wr_sync  <= '1;
      rd_hist  <= 1'b1;
      wr_hist  <= 1'b1;
      rd_stb   <= 1'b0;
      wr_stb   <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ext_busack_n};
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0], ebus_rd_n_in};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0], ebus_wr_n_in};
      rd_hist  <= rd_sync[SYNC_STAGES-1];
      wr_hist  <= wr_sync[SYNC_STAGES-1];
      rd_stb   <= rd_hist & ~rd_sync[SYNC_STAGES-1];
      wr_stb   <= wr_hist & ~wr_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: tb/tb_aqp_ebus_arbiter.sv
// Scoreboard bench for aqp_ebus_arbiter: stimulus pushes expected grants/strobes,
// a negedge monitor pops and compares them; directed checks cover timing gaps.
module tb_aqp_ebus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rr_mode, has_ext;
  logic [2:0]  m_req, m_gnt, m_d_oe, m_rd_n, m_wr_n, m_mreq_n, m_iorq_n;
  logic [47:0] m_a;
  logic [23:0] m_d;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_d_oe, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n, bus_oe;
  logic [1:0]  owner;
  logic        ext_busreq_n, ext_busack_n, ebus_rd_n_in, ebus_wr_n_in, rd_stb, wr_stb;

  aqp_ebus_arbiter #(.NUM_MASTERS(3), .SYNC_STAGES(2), .TURNAROUND(1)) dut (
    .clk(clk), .reset_n(reset_n), .rr_mode(rr_mode), .has_ext(has_ext),
    .m_req(m_req), .m_gnt(m_gnt), .m_a(m_a), .m_d(m_d), .m_d_oe(m_d_oe),
    .m_rd_n(m_rd_n), .m_wr_n(m_wr_n), .m_mreq_n(m_mreq_n), .m_iorq_n(m_iorq_n),
    .bus_a(bus_a), .bus_d(bus_d), .bus_d_oe(bus_d_oe), .bus_rd_n(bus_rd_n),
    .bus_wr_n(bus_wr_n), .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n),
    .bus_oe(bus_oe), .owner(owner), .ext_busreq_n(ext_busreq_n),
    .ext_busack_n(ext_busack_n), .ebus_rd_n_in(ebus_rd_n_in),
    .ebus_wr_n_in(ebus_wr_n_in), .rd_stb(rd_stb), .wr_stb(wr_stb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] gnt; int cyc; logic [15:0] a; } gnt_exp_t;
  typedef struct { logic rd; logic wr; int cyc; } stb_exp_t;

  gnt_exp_t   gnt_q[$];
  stb_exp_t   stb_q[$];
  gnt_exp_t   ge;
  stb_exp_t   se;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] prev_gnt = 3'b000;
  logic [15:0] a_exp [3] = '{16'h1100, 16'h2211, 16'h3322};
  int          rr_seq [4] = '{2, 0, 1, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int idx, input int when);
    gnt_exp_t e;
    e.gnt = 3'(3'b001 << idx);
    e.cyc = when;
    e.a   = a_exp[idx];
    gnt_q.push_back(e);
  endtask

  task automatic push_stb(input logic rd, input logic wr, input int when);
    stb_exp_t e;
    e.rd  = rd;
    e.wr  = wr;
    e.cyc = when;
    stb_q.push_back(e);
  endtask

  // Monitor: every new grant and every strobe pulse must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && m_gnt != 3'b000 && prev_gnt == 3'b000) begin
      if (gnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got %b at cycle %0d expected none", m_gnt, cyc);
      end else begin
        ge = gnt_q.pop_front();
        check("grant_vec", 32'(m_gnt), 32'(ge.gnt));
        check("grant_cycle", 32'(cyc), 32'(ge.cyc));
        check("grant_bus_a", 32'(bus_a), 32'(ge.a));
        check("grant_bus_oe", 32'(bus_oe), 32'd1);
      end
    end
    prev_gnt = m_gnt;
    if (reset_n === 1'b1 && (rd_stb || wr_stb)) begin
      if (stb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got rd=%b wr=%b at cycle %0d expected none", rd_stb, wr_stb, cyc);
      end else begin
        se = stb_q.pop_front();
        check("strobe_rd", 32'(rd_stb), 32'(se.rd));
        check("strobe_wr", 32'(wr_stb), 32'(se.wr));
        check("strobe_cycle", 32'(cyc), 32'(se.cyc));
      end
    end
  end

  initial begin
    reset_n      = 1'b1;
    rr_mode      = 1'b0;
    has_ext      = 1'b0;
    m_req        = 3'b000;
    m_a          = {16'h3322, 16'h2211, 16'h1100};
    m_d          = {8'hC3, 8'hA5, 8'h5A};
    m_d_oe       = 3'b001;
    m_rd_n       = 3'b111;
    m_wr_n       = 3'b111;
    m_mreq_n     = 3'b111;
    m_iorq_n     = 3'b111;
    ext_busack_n = 1'b1;
    ebus_rd_n_in = 1'b1;
    ebus_wr_n_in = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_m_gnt", 32'(m_gnt), 32'd0);
    check("rst_bus_oe", 32'(bus_oe), 32'd0);
    check("rst_bus_d_oe", 32'(bus_d_oe), 32'd0);
    check("rst_bus_strobes", 32'({bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n}), 32'hF);
    check("rst_busreq_n", 32'(ext_busreq_n), 32'd1);
    check("rst_owner", 32'(owner), 32'd2);
    check("rst_stb", 32'({rd_stb, wr_stb}), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // Single master, no external Z80: grant one cycle after request.
    m_req = 3'b001;
    push_gnt(0, cyc + 1);
    tick();
    check("t1_gnt", 32'(m_gnt), 32'b001);
    check("t1_bus_oe", 32'(bus_oe), 32'd1);
    check("t1_bus_d", 32'(bus_d), 32'h5A);
    check("t1_bus_d_oe", 32'(bus_d_oe), 32'd1);
    m_req = 3'b000;
    tick();
    check("t1_release_oe", 32'(bus_oe), 32'd0);
    check("t1_release_gnt", 32'(m_gnt), 32'd0);

    // Request arriving during RELEASE waits; fixed priority picks master 1 of 110.
    m_req = 3'b110;
    push_gnt(1, cyc + 2);
    tick();
    check("fp_gap_oe", 32'(bus_oe), 32'd0);
    tick();
    check("fp_owner", 32'(owner), 32'd1);
    check("fp_bus_d_oe", 32'(bus_d_oe), 32'd0);
    m_req = 3'b000;
    tick(3);

    // Round-robin from owner 1: each owner drops its request for one cycle to hand over.
    rr_mode = 1'b1;
    m_req = 3'b111;
    push_gnt(2, cyc + 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rr_owner", 32'(owner), 32'(rr_seq[i]));
      if (i == 3) m_req = 3'b000;
      else begin
        m_req = 3'b111 & ~(3'b001 << rr_seq[i]);
        push_gnt(rr_seq[i+1], cyc + 3);
      end
      tick();
      check("rr_gap_oe", 32'(bus_oe), 32'd0);
      if (i != 3) m_req = 3'b111;
      tick(2);
    end
    rr_mode = 1'b0;
    tick();

    // External Z80 handshake: no grant until synchronized BUSACK# low.
    has_ext = 1'b1;
    m_req = 3'b001;
    tick();
    check("ext_busreq_asserted", 32'(ext_busreq_n), 32'd0);
    tick(10);
    check("ext_no_grant", 32'(m_gnt), 32'd0);
    ext_busack_n = 1'b0;
    push_gnt(0, cyc + 3);
    tick(2);
    check("ext_not_early", 32'(m_gnt), 32'd0);
    tick();
    check("ext_gnt", 32'(m_gnt), 32'b001);

    // Dropped request is held while the owner's WR# is active.
    m_wr_n = 3'b110;
    m_req  = 3'b000;
    tick();
    check("hold_bus_wr_n", 32'(bus_wr_n), 32'd0);
    tick(2);
    check("hold_gnt", 32'(m_gnt), 32'b001);
    m_wr_n = 3'b111;
    tick();
    check("hold_release_gnt", 32'(m_gnt), 32'd0);
    check("hold_release_wr_n", 32'(bus_wr_n), 32'd1);
    check("hold_busreq_kept", 32'(ext_busreq_n), 32'd0);
    tick();
    check("busreq_deasserted", 32'(ext_busreq_n), 32'd1);
    ext_busack_n = 1'b1;
    has_ext = 1'b0;
    tick(3);

    // Strobes: 4-cycle WR# pulse, then a 2-cycle RD# pulse, one strobe each.
    ebus_wr_n_in = 1'b0;
    push_stb(1'b0, 1'b1, cyc + 3);
    tick(4);
    ebus_wr_n_in = 1'b1;
    tick(4);
    ebus_rd_n_in = 1'b0;
    push_stb(1'b1, 1'b0, cyc + 3);
    tick(2);
    ebus_rd_n_in = 1'b1;
    tick(4);
    check("stb_idle", 32'({rd_stb, wr_stb}), 32'd0);

    // Asynchronous reset in the middle of an external-bus grant.
    has_ext = 1'b1;
    m_req = 3'b001;
    tick();
    check("rst_test_busreq", 32'(ext_busreq_n), 32'd0);
    ext_busack_n = 1'b0;
    push_gnt(0, cyc + 3);
    tick(3);
    check("rst_test_gnt", 32'(m_gnt), 32'b001);
    #6 reset_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(m_gnt), 32'd0);
    check("async_rst_oe", 32'(bus_oe), 32'd0);
    check("async_rst_busreq", 32'(ext_busreq_n), 32'd1);
    check("async_rst_owner", 32'(owner), 32'd2);
    m_req = 3'b000;
    ext_busack_n = 1'b1;
    has_ext = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    m_req = 3'b100;
    push_gnt(2, cyc + 1);
    tick();
    check("post_rst_gnt", 32'(m_gnt), 32'b100);
    m_req = 3'b000;
    tick(3);

    check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);
    check("strobe_queue_empty", 32'(stb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
